// File: rtl/hafsa_sopc_cpu_oci_dtrace_ctrl_pkg.sv
// Shared types and constants for the OCI data-trace capture controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package hafsa_sopc_cpu_oci_dtrace_pkg;

    localparam int BUF_SLOTS = 15;
    localparam int BUF_W     = 2 * BUF_SLOTS;
    localparam int COUNT_W   = 4;
    localparam int TW_DATA_W = 34;
    localparam int ATOM_W    = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        FLUSH   = 2'd2,
        STOPPED = 2'd3
    } state_t;

    // Keeps only the payload bits that belong to an atom of the given size.
    function automatic logic [ATOM_W-1:0] atom_mask(input logic [1:0] slots);
        case (slots)
            2'd1:    return 6'h03;
            2'd2:    return 6'h0F;
            2'd3:    return 6'h3F;
            default: return 6'h00;
        endcase
    endfunction

endpackage

// File: rtl/hafsa_sopc_cpu_oci_dtrace_ctrl_if.sv
// Atom input channel and trace RAM write port of the data-trace controller.
// Latency: n/a (signal bundle only).
// Backpressure: atom_valid/atom_ready handshake; tw_req held until tw_ack.
// Ports: master = controller side, slave = atom source plus trace RAM side.
interface hafsa_sopc_cpu_oci_dtrace_ctrl_if #(
    parameter int TRACE_ADDR_W = 7
);
    logic                                            atom_valid;
    logic [hafsa_sopc_cpu_oci_dtrace_pkg::ATOM_W-1:0] atom_data;
    logic [1:0]                                      atom_slots;
    logic                                            atom_ready;

    logic                                               tw_req;
    logic [TRACE_ADDR_W-1:0]                            tw_addr;
    logic [hafsa_sopc_cpu_oci_dtrace_pkg::TW_DATA_W-1:0] tw_data;
    logic                                               tw_ack;

    modport master (
        input  atom_valid, atom_data, atom_slots, tw_ack,
        output atom_ready, tw_req, tw_addr, tw_data
    );

    modport slave (
        output atom_valid, atom_data, atom_slots, tw_ack,
        input  atom_ready, tw_req, tw_addr, tw_data
    );
endinterface

// File: rtl/hafsa_sopc_cpu_oci_dtrace_ctrl_wr.sv
// Hold register and trace RAM write handshake with address counter and wrap flag.
// Latency: a commit drives tw_req the cycle after it is loaded.
// Backpressure: hold stays valid (tw_addr/tw_data frozen) until tw_ack.
// Ports: clk/reset, clear (start of a new trace), commit_vld/commit_dat in,
//        tw_* write port, trc_wrapped, last_done (last address acked).
module hafsa_sopc_cpu_oci_dtrace_wr
    import hafsa_sopc_cpu_oci_dtrace_pkg::*;
#(
    parameter int TRACE_ADDR_W = 7
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    commit_vld,
    input  logic [TW_DATA_W-1:0]    commit_dat,
    input  logic                    tw_ack,
    output logic                    hold_vld,
    output logic [TRACE_ADDR_W-1:0] tw_addr,
    output logic [TW_DATA_W-1:0]    tw_data,
    output logic                    trc_wrapped,
    output logic                    last_done
);
    logic ack_take;
    logic at_last;

    assign ack_take  = hold_vld && tw_ack;
    assign at_last   = &tw_addr;
    assign last_done = ack_take && at_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_vld    <= 1'b0;
            tw_data     <= '0;
            tw_addr     <= '0;
            trc_wrapped <= 1'b0;
        end else begin
            // A new commit wins over the ack so hold can reload back-to-back.
            if (commit_vld) begin
                hold_vld <= 1'b1;
                tw_data  <= commit_dat;
            end else if (ack_take) begin
                hold_vld <= 1'b0;
            end

            if (clear) begin
                tw_addr     <= '0;
                trc_wrapped <= 1'b0;
            end else if (ack_take) begin
                tw_addr <= tw_addr + 1'b1;
                if (at_last) begin
                    trc_wrapped <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/hafsa_sopc_cpu_oci_dtrace_ctrl.sv
// OCI data-trace controller: packs 1..3-slot atoms into dct_buffer and commits buffers to trace RAM.
// Latency: a filled or flushed buffer reaches tw_req one cycle after the commit decision.
// Backpressure: atom_ready drops while the hold register is busy and the buffer might overflow.
// Ports: clk/reset, trc_on/trc_wrap/flush controls, bus (atom channel + write port),
//        dct_buffer/dct_count packing view, trc_wrapped/trc_stopped/trc_busy status.
module hafsa_sopc_cpu_oci_dtrace_ctrl
    import hafsa_sopc_cpu_oci_dtrace_pkg::*;
#(
    parameter int TRACE_ADDR_W = 7
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              trc_on,
    input  logic                              trc_wrap,
    input  logic                              flush,
    hafsa_sopc_cpu_oci_dtrace_ctrl_if.master  bus,
    output logic [BUF_W-1:0]                  dct_buffer,
    output logic [COUNT_W-1:0]                dct_count,
    output logic                              trc_wrapped,
    output logic                              trc_stopped,
    output logic                              trc_busy
);
    state_t               state, state_nxt;
    logic [BUF_W-1:0]     buf_q, buf_nxt;
    logic [COUNT_W-1:0]   cnt_q, cnt_nxt;
    logic                 pulse_q, pulse_nxt;

    logic                 hold_vld;
    logic                 last_done;
    logic                 commit_vld;
    logic [TW_DATA_W-1:0] commit_dat;
    logic                 clear;
    logic                 accept;
    logic [COUNT_W:0]     sum;
    logic [BUF_W-1:0]     atom_bits;
    logic [BUF_W-1:0]     shifted;

    // With count <= 11 no legal atom can fill the buffer, so accepting while
    // hold is busy can never need a second commit.
    assign bus.atom_ready = (state == RUN) && (!hold_vld || cnt_q <= 4'd11);
    assign accept         = bus.atom_valid && bus.atom_ready && (bus.atom_slots != 2'd0);

    assign sum       = {1'b0, cnt_q} + {3'b000, bus.atom_slots};
    assign atom_bits = {{(BUF_W-ATOM_W){1'b0}}, bus.atom_data & atom_mask(bus.atom_slots)};
    assign shifted   = (buf_q << {bus.atom_slots, 1'b0}) | atom_bits;

    always_comb begin
        state_nxt  = state;
        buf_nxt    = buf_q;
        cnt_nxt    = cnt_q;
        pulse_nxt  = pulse_q;
        commit_vld = 1'b0;
        commit_dat = '0;
        clear      = 1'b0;
        case (state)
            IDLE: begin
                if (trc_on) begin
                    state_nxt = RUN;
                    clear     = 1'b1;
                    buf_nxt   = '0;
                    cnt_nxt   = '0;
                end
            end
            RUN: begin
                if (accept) begin
                    if (sum < (COUNT_W+1)'(BUF_SLOTS)) begin
                        buf_nxt = shifted;
                        cnt_nxt = sum[COUNT_W-1:0];
                    end else if (sum == (COUNT_W+1)'(BUF_SLOTS)) begin
                        commit_vld = 1'b1;
                        commit_dat = {COUNT_W'(BUF_SLOTS), shifted};
                        buf_nxt    = '0;
                        cnt_nxt    = '0;
                    end else begin
                        // Atom does not fit: ship the old buffer, start afresh with the atom.
                        commit_vld = 1'b1;
                        commit_dat = {cnt_q, buf_q};
                        buf_nxt    = atom_bits;
                        cnt_nxt    = {2'b00, bus.atom_slots};
                    end
                end
                // A full RAM without wrap ends the trace even if a flush arrives together.
                if (last_done && !trc_wrap) begin
                    state_nxt = STOPPED;
                end else if (flush || !trc_on) begin
                    state_nxt = FLUSH;
                    pulse_nxt = flush;
                end
            end
            FLUSH: begin
                if (!hold_vld) begin
                    if (cnt_q != '0) begin
                        commit_vld = 1'b1;
                        commit_dat = {cnt_q, buf_q};
                        buf_nxt    = '0;
                        cnt_nxt    = '0;
                    end else begin
                        state_nxt = (trc_on && pulse_q) ? RUN : IDLE;
                    end
                end
            end
            STOPPED: begin
                if (!trc_on) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            buf_q   <= '0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            buf_q   <= buf_nxt;
            cnt_q   <= cnt_nxt;
            pulse_q <= pulse_nxt;
        end
    end

    hafsa_sopc_cpu_oci_dtrace_wr #(
        .TRACE_ADDR_W (TRACE_ADDR_W)
    ) u_wr (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .commit_vld  (commit_vld),
        .commit_dat  (commit_dat),
        .tw_ack      (bus.tw_ack),
        .hold_vld    (hold_vld),
        .tw_addr     (bus.tw_addr),
        .tw_data     (bus.tw_data),
        .trc_wrapped (trc_wrapped),
        .last_done   (last_done)
    );

    assign bus.tw_req  = hold_vld;
    assign dct_buffer  = buf_q;
    assign dct_count   = cnt_q;
    assign trc_stopped = (state == STOPPED);
    assign trc_busy    = (state == RUN) || (state == FLUSH);
endmodule

// File: tb/tb_hafsa_sopc_cpu_oci_dtrace_ctrl.sv
module tb_hafsa_sopc_cpu_oci_dtrace_ctrl;
    localparam int AW   = 2;
    localparam int AMAX = (1 << AW) - 1;
    localparam int M_IDLE = 0, M_RUN = 1, M_FLUSH = 2, M_STOP = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        trc_on = 1'b0;
    logic        trc_wrap = 1'b0;
    logic        flush = 1'b0;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        trc_wrapped, trc_stopped, trc_busy;

    int checks = 0;
    int errors = 0;

    hafsa_sopc_cpu_oci_dtrace_ctrl_if #(.TRACE_ADDR_W(AW)) ifc ();

    hafsa_sopc_cpu_oci_dtrace_ctrl #(.TRACE_ADDR_W(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .trc_on      (trc_on),
        .trc_wrap    (trc_wrap),
        .flush       (flush),
        .bus         (ifc),
        .dct_buffer  (dct_buffer),
        .dct_count   (dct_count),
        .trc_wrapped (trc_wrapped),
        .trc_stopped (trc_stopped),
        .trc_busy    (trc_busy)
    );

    always #5 clk = ~clk;

    // Behavioural model: the packing buffer is a queue of 2-bit slots, oldest first.
    int          m_mode;
    bit          m_pulse;
    logic [1:0]  m_slots[$];
    bit          m_hold;
    logic [33:0] m_word;
    int          m_addr;
    bit          m_wrapped;

    function automatic logic [29:0] m_buf();
        logic [29:0] v = '0;
        foreach (m_slots[i]) v = (v << 2) | 30'(m_slots[i]);
        return v;
    endfunction

    function automatic bit m_ready();
        return (m_mode == M_RUN) && (!m_hold || m_slots.size() <= 11);
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_pulse = 0; m_slots.delete();
        m_hold = 0; m_word = '0; m_addr = 0; m_wrapped = 0;
    endtask

    task automatic model_step();
        bit          hold_old = m_hold;
        bit          ready    = m_ready();
        bit          ack      = m_hold && ifc.tw_ack;
        bit          last     = ack && (m_addr == AMAX);
        bit          do_commit = 0;
        logic [33:0] word = '0;
        int          s;
        case (m_mode)
            M_IDLE: if (trc_on) begin
                m_mode = M_RUN; m_addr = 0; m_wrapped = 0; m_slots.delete();
            end
            M_RUN: begin
                if (ifc.atom_valid && ready && ifc.atom_slots != 0) begin
                    s = int'(ifc.atom_slots);
                    if (m_slots.size() + s > 15) begin
                        word = {4'(m_slots.size()), m_buf()}; do_commit = 1; m_slots.delete();
                    end
                    for (int k = s - 1; k >= 0; k--) m_slots.push_back(ifc.atom_data[2*k +: 2]);
                    if (m_slots.size() == 15) begin
                        word = {4'd15, m_buf()}; do_commit = 1; m_slots.delete();
                    end
                end
                if (last && !trc_wrap) m_mode = M_STOP;
                else if (flush || !trc_on) begin m_mode = M_FLUSH; m_pulse = flush; end
            end
            M_FLUSH: if (!hold_old) begin
                if (m_slots.size() != 0) begin
                    word = {4'(m_slots.size()), m_buf()}; do_commit = 1; m_slots.delete();
                end else begin
                    m_mode = (trc_on && m_pulse) ? M_RUN : M_IDLE;
                end
            end
            default: if (!trc_on) m_mode = M_IDLE;
        endcase
        if (ack) begin
            m_hold = 0;
            m_addr = (m_addr + 1) % (AMAX + 1);
            if (m_addr == 0) m_wrapped = 1;
        end
        if (do_commit) begin m_hold = 1; m_word = word; end
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("atom_ready", 64'(ifc.atom_ready), 64'(m_ready()));
        chk("dct_count", 64'(dct_count), 64'(m_slots.size()));
        chk("dct_buffer", 64'(dct_buffer), 64'(m_buf()));
        chk("tw_req", 64'(ifc.tw_req), 64'(m_hold));
        chk("tw_addr", 64'(ifc.tw_addr), 64'(m_addr));
        if (m_hold) chk("tw_data", 64'(ifc.tw_data), 64'(m_word));
        chk("trc_wrapped", 64'(trc_wrapped), 64'(m_wrapped));
        chk("trc_stopped", 64'(trc_stopped), 64'(m_mode == M_STOP));
        chk("trc_busy", 64'(trc_busy), 64'(m_mode == M_RUN || m_mode == M_FLUSH));
    endtask

    // One clock: model follows the inputs present at the edge, outputs checked at the falling edge.
    task automatic tick();
        @(posedge clk);
        if (!reset) model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(input bit v, input logic [1:0] s, input logic [5:0] d);
        ifc.atom_valid = v; ifc.atom_slots = s; ifc.atom_data = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; trc_on = 0; flush = 0; ifc.tw_ack = 0; drive(0, 2'd0, 6'h0);
        model_reset();
        @(negedge clk);
        compare_all();
        reset = 1'b0;
    endtask

    int wr_addr[$];
    bit wrapped_at5;
    int n;

    initial begin
        drive(0, 2'd0, 6'h0);
        ifc.tw_ack = 1'b0;
        model_reset();
        do_reset();
        chk("reset tw_req", 64'(ifc.tw_req), 0);
        chk("reset dct_count", 64'(dct_count), 0);
        chk("reset busy", 64'(trc_busy), 0);

        // Five 3-slot atoms fill exactly one buffer.
        trc_on = 1; ifc.tw_ack = 1; tick();
        drive(1, 2'd3, 6'h2A);
        repeat (5) tick();
        chk("A tw_req", 64'(ifc.tw_req), 1);
        chk("A tw_addr", 64'(ifc.tw_addr), 0);
        chk("A tw_data", 64'(ifc.tw_data), 64'h3_EAAA_AAAA);
        chk("A dct_count", 64'(dct_count), 0);
        drive(0, 2'd0, 6'h0); tick();

        // Count 14 then a 2-slot atom spills the old buffer.
        drive(1, 2'd3, 6'h2A); repeat (4) tick();
        drive(1, 2'd2, 6'h2A); tick();
        chk("B count14", 64'(dct_count), 14);
        drive(1, 2'd2, 6'h03); tick();
        chk("B dct_buffer", 64'(dct_buffer), 30'h3);
        chk("B dct_count", 64'(dct_count), 2);
        chk("B tw_req", 64'(ifc.tw_req), 1);
        chk("B hold count", 64'(ifc.tw_data[33:30]), 14);

        // Stall: hold busy, count reaches 12.
        ifc.tw_ack = 0;
        drive(1, 2'd3, 6'h15); repeat (3) tick();
        drive(1, 2'd1, 6'h01); tick();
        chk("C count12", 64'(dct_count), 12);
        chk("C ready low", 64'(ifc.atom_ready), 0);
        repeat (2) tick();
        drive(0, 2'd0, 6'h0); ifc.tw_ack = 1; tick();
        ifc.tw_ack = 0; tick();
        chk("C ready high", 64'(ifc.atom_ready), 1);

        // Flush of a 5-slot partial buffer.
        do_reset();
        trc_on = 1; ifc.tw_ack = 1; tick();
        drive(1, 2'd3, 6'h15); tick();
        drive(1, 2'd2, 6'h0E); tick();
        drive(0, 2'd0, 6'h0);
        chk("D buffer", 64'(dct_buffer), 30'h15E);
        flush = 1; tick(); flush = 0;
        chk("D flush busy", 64'(trc_busy), 1);
        chk("D flush ready", 64'(ifc.atom_ready), 0);
        drive(1, 2'd1, 6'h3); tick();
        chk("D tw_req", 64'(ifc.tw_req), 1);
        chk("D tw_data", 64'(ifc.tw_data), {4'h5, 30'h15E});
        repeat (2) tick();
        chk("D back to run", 64'(ifc.atom_ready), 1);
        drive(0, 2'd0, 6'h0); tick();

        // No-wrap: four writes then STOPPED.
        do_reset();
        trc_wrap = 0; trc_on = 1; ifc.tw_ack = 1; drive(1, 2'd3, 6'h2A);
        wr_addr.delete(); n = 0;
        while (!trc_stopped && n < 80) begin
            if (ifc.tw_req && ifc.tw_ack) wr_addr.push_back(int'(ifc.tw_addr));
            tick(); n++;
        end
        chk("E stop in budget", 64'(n < 80), 1);
        chk("E writes", 64'(wr_addr.size()), 4);
        foreach (wr_addr[i]) chk("E addr", 64'(wr_addr[i]), 64'(i));
        chk("E stopped", 64'(trc_stopped), 1);

        // Wrap: fifth write lands on address 0.
        do_reset();
        trc_wrap = 1; trc_on = 1; ifc.tw_ack = 1; drive(1, 2'd3, 6'h2A);
        wr_addr.delete(); n = 0; wrapped_at5 = 0;
        while (wr_addr.size() < 5 && n < 100) begin
            if (ifc.tw_req && ifc.tw_ack) begin
                wr_addr.push_back(int'(ifc.tw_addr));
                if (wr_addr.size() == 5) wrapped_at5 = trc_wrapped;
            end
            tick(); n++;
        end
        chk("W writes", 64'(wr_addr.size()), 5);
        if (wr_addr.size() == 5) chk("W addr5", 64'(wr_addr[4]), 0);
        chk("W wrapped", 64'(wrapped_at5), 1);

        // Reset in the middle of a pending write.
        do_reset();
        trc_on = 1; ifc.tw_ack = 0; tick();
        drive(1, 2'd3, 6'h2A); repeat (7) tick();
        drive(1, 2'd1, 6'h1); tick();
        drive(0, 2'd0, 6'h0);
        chk("F count7", 64'(dct_count), 7);
        chk("F req", 64'(ifc.tw_req), 1);
        reset = 1; #1;
        chk("F rst req", 64'(ifc.tw_req), 0);
        chk("F rst count", 64'(dct_count), 0);
        chk("F rst buffer", 64'(dct_buffer), 0);
        chk("F rst busy", 64'(trc_busy), 0);
        model_reset();
        @(negedge clk); compare_all();
        reset = 0; tick();
        chk("F run after reset", 64'(trc_busy), 1);

        // Randomized traffic.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(999) == 0) do_reset();
            trc_on      = ($urandom_range(99) < 97);
            flush       = ($urandom_range(99) < 4);
            if ($urandom_range(99) == 0) trc_wrap = ~trc_wrap;
            ifc.tw_ack  = $urandom_range(1);
            drive($urandom_range(99) < 70, 2'($urandom_range(3)), 6'($urandom));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
